// File: rtl/ysyx_23060251_ifu_pkg.sv
// Shared widths, reset PC and state encoding for the fetch unit.
// Optional perf counters: YSYX_23060251_IFU_PERF_EN.
package ysyx_23060251_ifu_pkg;

  localparam int IFU_PC_W   = 32;
  localparam int IFU_INST_W = 32;

  localparam logic [IFU_PC_W-1:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ysyx_23060251_ifu_pc_gen.sv
// PC register, +4 adder, redirect mux and the drop flag
// that marks the single outstanding response as stale.
module ysyx_23060251_ifu_pc_gen
  import ysyx_23060251_ifu_pkg::*;
#(
  parameter int               PC_W     = IFU_PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  ifu_state_t      state,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            r_fire,
  input  logic            d_fire,
  output logic [PC_W-1:0] pc_nxt,
  output logic            drop
);

  logic [PC_W-1:0] pc;
  logic            in_flight;

  // a request is still owed a response unless it is arriving now
  assign in_flight = (state == REQ) ||
                     ((state == WAIT) && !r_fire);

  // redirect beats sequential advance
  always_comb begin
    pc_nxt = pc;
    if (redirect_valid)
      pc_nxt = redirect_pc;
    else if (d_fire)
      pc_nxt = pc + PC_W'(4);
  end

  // pc follows pc_nxt; drop is set by a redirect that overtakes
  // an outstanding request and cleared when that response lands
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      drop <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (redirect_valid && in_flight)
        drop <= 1'b1;
      else if (r_fire)
        drop <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060251_ifu.sv
// Instruction fetch unit: one AR/R read outstanding, {inst, pc} to IF/ID.
// Define YSYX_23060251_IFU_PERF_EN to add fetch/stall counters.
module ysyx_23060251_ifu
  import ysyx_23060251_ifu_pkg::*;
#(
  parameter logic [IFU_PC_W-1:0] RESET_PC = IFU_RESET_PC,
  parameter int                  PC_W     = IFU_PC_W,
  parameter int                  INST_W   = IFU_INST_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              ifu_arvalid_o,
  output logic [PC_W-1:0]   ifu_araddr_o,
  input  logic              ifu_arready_i,
  input  logic              ifu_rvalid_i,
  input  logic [INST_W-1:0] ifu_rdata_i,
  output logic              ifu_rready_o,
  output logic [INST_W-1:0] f_inst_o,
  output logic [PC_W-1:0]   f_pc_o,
  output logic              f_valid_o,
  input  logic              D_ready_i
`ifdef YSYX_23060251_IFU_PERF_EN
  ,
  output logic [63:0]       ifu_fetch_cnt_o,
  output logic [63:0]       ifu_stall_cnt_o
`endif
);

  ifu_state_t      state;
  logic [PC_W-1:0] pc_nxt;
  logic            drop;
  logic            r_fire;
  logic            d_fire;

  assign r_fire = (state == WAIT) && ifu_rvalid_i;
  assign d_fire = (state == HOLD) && D_ready_i;

  ysyx_23060251_ifu_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (PC_W'(RESET_PC))
  ) u_pc_gen (
    .clk            (clk_i),
    .rst            (rst_i),
    .state          (state),
    .redirect_valid (redirect_valid_i),
    .redirect_pc    (redirect_pc_i),
    .r_fire         (r_fire),
    .d_fire         (d_fire),
    .pc_nxt         (pc_nxt),
    .drop           (drop)
  );

  // fetch FSM with registered bus and IF/ID outputs;
  // araddr is latched only on entry to REQ so it holds during AR stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      ifu_arvalid_o <= 1'b0;
      ifu_araddr_o  <= '0;
      ifu_rready_o  <= 1'b0;
      f_valid_o     <= 1'b0;
      f_pc_o        <= '0;
      f_inst_o      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state         <= REQ;
          ifu_arvalid_o <= 1'b1;
          ifu_araddr_o  <= pc_nxt;
        end
        REQ: begin
          if (ifu_arready_i) begin
            state         <= WAIT;
            ifu_arvalid_o <= 1'b0;
            ifu_rready_o  <= 1'b1;
          end
        end
        WAIT: begin
          if (ifu_rvalid_i) begin
            ifu_rready_o <= 1'b0;
            if (drop || redirect_valid_i) begin
              state         <= REQ;
              ifu_arvalid_o <= 1'b1;
              ifu_araddr_o  <= pc_nxt;
            end else begin
              state     <= HOLD;
              f_valid_o <= 1'b1;
              f_inst_o  <= ifu_rdata_i;
              f_pc_o    <= ifu_araddr_o;
            end
          end
        end
        HOLD: begin
          if (redirect_valid_i || D_ready_i) begin
            state         <= REQ;
            f_valid_o     <= 1'b0;
            ifu_arvalid_o <= 1'b1;
            ifu_araddr_o  <= pc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef YSYX_23060251_IFU_PERF_EN
  // count accepted fetches and cycles spent waiting on memory
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifu_fetch_cnt_o <= '0;
      ifu_stall_cnt_o <= '0;
    end else begin
      if (f_valid_o && D_ready_i)
        ifu_fetch_cnt_o <= ifu_fetch_cnt_o + 64'd1;
      if ((state == REQ) || (state == WAIT))
        ifu_stall_cnt_o <= ifu_stall_cnt_o + 64'd1;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule
